// File: rtl/picorv32_arb_pkg.sv
// rtl/picorv32_arb_pkg.sv - shared state, owner and timer-width definitions for the memory arbiter
package picorv32_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_ABORT = 2'd2
    } arb_state_t;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_R0   = 2'd1;
    localparam logic [1:0] OWN_R1   = 2'd2;

    // Width that can hold 0..timeout; never narrower than one bit.
    function automatic int TIMER_W(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/picorv32_arb_rr2.sv
// rtl/picorv32_arb_rr2.sv - two-way round-robin / fixed-priority pick
module picorv32_arb_rr2 #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last_grant,
    output logic o_any,
    output logic o_win
);

    assign o_any = i_req0 | i_req1;

    // o_win: 0 selects requester 0, 1 selects requester 1.
    always_comb begin
        o_win = ~i_req0;
        if (!FIXED_PRIO && i_req0 && i_req1) begin
            o_win = ~i_last_grant;
        end
    end

endmodule

// File: rtl/picorv32_mem_arbiter.sv
// rtl/picorv32_mem_arbiter.sv - shares one PicoRV32 native memory port between core and ISAX requesters
module picorv32_mem_arbiter
    import picorv32_arb_pkg::*;
#(
    parameter int          TIMEOUT    = 256,
    parameter logic [31:0] ERR_RDATA  = 32'hDEAD_BEEF,
    parameter int          FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        r0_valid,
    input  logic        r0_instr,
    input  logic [31:0] r0_addr,
    input  logic [31:0] r0_wdata,
    input  logic [3:0]  r0_wstrb,
    output logic        r0_ready,
    output logic [31:0] r0_rdata,
    input  logic        r1_valid,
    input  logic        r1_instr,
    input  logic [31:0] r1_addr,
    input  logic [31:0] r1_wdata,
    input  logic [3:0]  r1_wstrb,
    output logic        r1_ready,
    output logic [31:0] r1_rdata,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  owner,
    output logic        timeout_err
);

    localparam int            TW         = TIMER_W(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    arb_state_t    r_state;
    logic          r_last_grant;
    logic [TW-1:0] r_timer;
    logic          r_mem_valid;
    logic          r_mem_instr;
    logic [31:0]   r_mem_addr;
    logic [31:0]   r_mem_wdata;
    logic [3:0]    r_mem_wstrb;
    logic          r_r0_ready;
    logic [31:0]   r_r0_rdata;
    logic          r_r1_ready;
    logic [31:0]   r_r1_rdata;
    logic [1:0]    r_owner;
    logic          r_timeout_err;

    logic          w_any;
    logic          w_win;
    logic          w_resp_cycle;
    logic          w_expire;
    logic [31:0]   w_resp_data;

    picorv32_arb_rr2 #(
        .FIXED_PRIO (FIXED_PRIO != 0)
    ) u_pick (
        .i_req0       (r0_valid),
        .i_req1       (r1_valid),
        .i_last_grant (r_last_grant),
        .o_any        (w_any),
        .o_win        (w_win)
    );

    // The cycle carrying a ready pulse is not an arbitration cycle: the
    // requester still shows the valid of the request that just finished.
    assign w_resp_cycle = r_r0_ready | r_r1_ready;
    assign w_expire     = (TIMEOUT != 0) && (r_timer == TIMER_LAST);
    assign w_resp_data  = mem_ready ? mem_rdata : ERR_RDATA;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= ST_IDLE;
            r_last_grant  <= 1'b1;
            r_timer       <= '0;
            r_mem_valid   <= 1'b0;
            r_mem_instr   <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_mem_wstrb   <= '0;
            r_r0_ready    <= 1'b0;
            r_r0_rdata    <= '0;
            r_r1_ready    <= 1'b0;
            r_r1_rdata    <= '0;
            r_owner       <= OWN_NONE;
            r_timeout_err <= 1'b0;
        end else begin
            r_r0_ready    <= 1'b0;
            r_r1_ready    <= 1'b0;
            r_timeout_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any && !w_resp_cycle) begin
                        r_mem_valid  <= 1'b1;
                        r_mem_instr  <= w_win ? r1_instr : r0_instr;
                        r_mem_addr   <= w_win ? r1_addr  : r0_addr;
                        r_mem_wdata  <= w_win ? r1_wdata : r0_wdata;
                        r_mem_wstrb  <= w_win ? r1_wstrb : r0_wstrb;
                        r_owner      <= w_win ? OWN_R1 : OWN_R0;
                        r_last_grant <= w_win;
                        r_timer      <= '0;
                        r_state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (mem_ready || w_expire) begin
                        if (r_owner == OWN_R1) begin
                            r_r1_ready <= 1'b1;
                            r_r1_rdata <= w_resp_data;
                        end else begin
                            r_r0_ready <= 1'b1;
                            r_r0_rdata <= w_resp_data;
                        end
                        r_mem_valid   <= 1'b0;
                        r_owner       <= OWN_NONE;
                        r_timeout_err <= ~mem_ready;
                        r_state       <= mem_ready ? ST_IDLE : ST_ABORT;
                    end else if (r_timer != '1) begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                ST_ABORT: r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    assign mem_valid   = r_mem_valid;
    assign mem_instr   = r_mem_instr;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign mem_wstrb   = r_mem_wstrb;
    assign r0_ready    = r_r0_ready;
    assign r0_rdata    = r_r0_rdata;
    assign r1_ready    = r_r1_ready;
    assign r1_rdata    = r_r1_rdata;
    assign owner       = r_owner;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// tb/tb_picorv32_mem_arbiter.sv - self-checking bench for picorv32_mem_arbiter
module tb_picorv32_mem_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        r0_valid, r0_instr, r1_valid, r1_instr;
    logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
    logic [3:0]  r0_wstrb, r1_wstrb;
    logic        r0_ready, r1_ready;
    logic [31:0] r0_rdata, r1_rdata;
    logic        mem_valid, mem_instr, mem_ready, timeout_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic [1:0]  owner;

    logic        b_r0_ready, b_r1_ready, b_mem_valid, b_mem_instr, b_timeout_err;
    logic [31:0] b_r0_rdata, b_r1_rdata, b_mem_addr, b_mem_wdata;
    logic [3:0]  b_mem_wstrb;
    logic [1:0]  b_owner;
    logic        b_mem_ready = 1'b0;
    logic [31:0] b_mem_rdata = '0;

    int n_cmp = 0;
    int n_err = 0;
    int m_last;

    always #5 clk = ~clk;

    picorv32_mem_arbiter #(.TIMEOUT(8), .ERR_RDATA(32'hDEAD_BEEF), .FIXED_PRIO(0)) dut (
        .clk(clk), .resetn(resetn),
        .r0_valid(r0_valid), .r0_instr(r0_instr), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_wstrb(r0_wstrb), .r0_ready(r0_ready), .r0_rdata(r0_rdata),
        .r1_valid(r1_valid), .r1_instr(r1_instr), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_wstrb(r1_wstrb), .r1_ready(r1_ready), .r1_rdata(r1_rdata),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .owner(owner), .timeout_err(timeout_err)
    );

    picorv32_mem_arbiter #(.TIMEOUT(0), .ERR_RDATA(32'hDEAD_BEEF), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .resetn(resetn),
        .r0_valid(r0_valid), .r0_instr(r0_instr), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_wstrb(r0_wstrb), .r0_ready(b_r0_ready), .r0_rdata(b_r0_rdata),
        .r1_valid(r1_valid), .r1_instr(r1_instr), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_wstrb(r1_wstrb), .r1_ready(b_r1_ready), .r1_rdata(b_r1_rdata),
        .mem_valid(b_mem_valid), .mem_instr(b_mem_instr), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_wstrb(b_mem_wstrb), .mem_ready(b_mem_ready), .mem_rdata(b_mem_rdata),
        .owner(b_owner), .timeout_err(b_timeout_err)
    );

    // Fixed-priority instance gets an always-willing memory.
    always @(negedge clk) begin
        b_mem_ready = b_mem_valid & ~b_mem_ready;
        b_mem_rdata = b_mem_addr ^ 32'h5555_5555;
    end

    task automatic idle_inputs;
        r0_valid = 0; r0_instr = 0; r0_addr = '0; r0_wdata = '0; r0_wstrb = '0;
        r1_valid = 0; r1_instr = 0; r1_addr = '0; r1_wdata = '0; r1_wstrb = '0;
        mem_ready = 0; mem_rdata = '0;
    endtask

    task automatic test_reset;
        resetn = 0;
        idle_inputs();
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb} !== 70'd0) begin
            n_err++; $display("FAIL reset_mem: got %b/%h/%h/%h expected all zero", mem_valid, mem_addr, mem_wdata, mem_wstrb);
        end
        n_cmp++;
        if ({r0_ready, r1_ready, owner, timeout_err} !== 5'd0) begin
            n_err++; $display("FAIL reset_ctrl: got r0_ready=%b r1_ready=%b owner=%0d terr=%b expected zeros", r0_ready, r1_ready, owner, timeout_err);
        end
        n_cmp++;
        if ({b_mem_valid, b_owner} !== 3'd0) begin
            n_err++; $display("FAIL reset_fp: got mem_valid=%b owner=%0d expected 0", b_mem_valid, b_owner);
        end
        resetn = 1;
        m_last = 1;
        @(negedge clk);
    endtask

    task automatic test_single_read;
        r0_valid = 1; r0_addr = 32'h100; r0_wstrb = 4'd0; r0_instr = 0; r0_wdata = $urandom;
        @(negedge clk);
        n_cmp++;
        if (mem_valid !== 1'b1 || owner !== 2'd1 || mem_addr !== 32'h100 || mem_wstrb !== 4'd0) begin
            n_err++; $display("FAIL read_issue: got valid=%b owner=%0d addr=%h wstrb=%h expected 1/1/100/0", mem_valid, owner, mem_addr, mem_wstrb);
        end
        m_last = 0;
        @(negedge clk);
        n_cmp++;
        if (mem_valid !== 1'b1 || r0_ready !== 1'b0) begin
            n_err++; $display("FAIL read_hold: got valid=%b r0_ready=%b expected 1/0", mem_valid, r0_ready);
        end
        mem_ready = 1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        mem_ready = 0; mem_rdata = $urandom;
        n_cmp++;
        if (r0_ready !== 1'b1 || r0_rdata !== 32'h1234_5678 || owner !== 2'd0 || mem_valid !== 1'b0 || r1_ready !== 1'b0) begin
            n_err++; $display("FAIL read_resp: got r0_ready=%b rdata=%h owner=%0d valid=%b r1_ready=%b expected 1/12345678/0/0/0",
                              r0_ready, r0_rdata, owner, mem_valid, r1_ready);
        end
        r0_valid = 0;
        @(negedge clk);
        n_cmp++;
        if (r0_ready !== 1'b0 || r0_rdata !== 32'h1234_5678 || r1_ready !== 1'b0) begin
            n_err++; $display("FAIL read_pulse: got r0_ready=%b rdata=%h r1_ready=%b expected 0/12345678/0", r0_ready, r0_rdata, r1_ready);
        end
    endtask

    task automatic test_write_passthrough;
        int lat, nv, nrdy, n0, bad;
        logic [31:0] rv;
        lat = $urandom_range(1, 4);
        rv = $urandom;
        mem_rdata = rv;
        nv = 0; nrdy = 0; n0 = 0; bad = 0;
        r1_valid = 1; r1_addr = 32'h2000; r1_wdata = 32'hA5A5_A5A5; r1_wstrb = 4'b0011; r1_instr = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            mem_ready = 0;
            if (r1_ready === 1'b1) begin nrdy++; r1_valid = 0; end
            if (r0_ready === 1'b1) n0++;
            if (mem_valid === 1'b1) begin
                nv++;
                if ({mem_addr, mem_wdata, mem_wstrb, owner} !== {32'h2000, 32'hA5A5_A5A5, 4'b0011, 2'd2}) bad++;
                if (nv == lat) mem_ready = 1;
            end
        end
        r1_valid = 0;
        m_last = 1;
        n_cmp++;
        if (bad != 0) begin n_err++; $display("FAIL write_payload: got %0d unstable cycles expected 0", bad); end
        n_cmp++;
        if (nv != lat) begin n_err++; $display("FAIL write_valid_cycles: got %0d expected %0d", nv, lat); end
        n_cmp++;
        if (nrdy != 1 || n0 != 0 || r1_rdata !== rv) begin
            n_err++; $display("FAIL write_ready: got r1 pulses=%0d r0 pulses=%0d rdata=%h expected 1/0/%h", nrdy, n0, r1_rdata, rv);
        end
    endtask

    task automatic test_tie;
        logic [1:0] ga[$];
        logic [1:0] gb[$];
        logic       prev_a, prev_b;
        logic [1:0] exp_own;
        prev_a = 0; prev_b = 0;
        r0_valid = 1; r0_addr = 32'h1000; r0_wstrb = 0;
        r1_valid = 1; r1_addr = 32'h3000; r1_wstrb = 0;
        for (int c = 0; c < 80 && (ga.size() < 4 || gb.size() < 4); c++) begin
            @(negedge clk);
            mem_ready = 0;
            if (mem_valid && !prev_a) ga.push_back(owner);
            if (b_mem_valid && !prev_b) gb.push_back(b_owner);
            if (mem_valid && prev_a) begin mem_ready = 1; mem_rdata = $urandom; end
            prev_a = mem_valid; prev_b = b_mem_valid;
        end
        r0_valid = 0; r1_valid = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            mem_ready = mem_valid & ~mem_ready;
        end
        mem_ready = 0;
        for (int i = 0; i < 4; i++) begin
            exp_own = (m_last == 0) ? 2'd2 : 2'd1;
            m_last = (exp_own == 2'd2) ? 1 : 0;
            n_cmp++;
            if (i >= ga.size()) begin
                n_err++; $display("FAIL rr_grant%0d: got no grant expected owner %0d", i, exp_own);
            end else if (ga[i] !== exp_own) begin
                n_err++; $display("FAIL rr_grant%0d: got owner %0d expected %0d", i, ga[i], exp_own);
            end
            n_cmp++;
            if (i >= gb.size()) begin
                n_err++; $display("FAIL fp_grant%0d: got no grant expected owner 1", i);
            end else if (gb[i] !== 2'd1) begin
                n_err++; $display("FAIL fp_grant%0d: got owner %0d expected 1", i, gb[i]);
            end
        end
    endtask

    task automatic test_timeout;
        int  nv;
        bit  found;
        logic [31:0] rv;
        nv = 0; found = 0;
        r0_valid = 1; r0_addr = $urandom; r0_wstrb = 0;
        for (int c = 0; c < 30 && !found; c++) begin
            @(negedge clk);
            if (mem_valid === 1'b1) nv++;
            else if (nv > 0) begin
                found = 1;
                n_cmp++;
                if (r0_ready !== 1'b1 || r0_rdata !== 32'hDEAD_BEEF || timeout_err !== 1'b1 || owner !== 2'd0 || r1_ready !== 1'b0) begin
                    n_err++; $display("FAIL timeout_abort: got r0_ready=%b rdata=%h terr=%b owner=%0d r1_ready=%b expected 1/deadbeef/1/0/0",
                                      r0_ready, r0_rdata, timeout_err, owner, r1_ready);
                end
                r0_valid = 0;
            end
        end
        m_last = 0;
        n_cmp++;
        if (!found || nv != 8) begin n_err++; $display("FAIL timeout_cycles: got %0d issue cycles (abort seen=%0d) expected 8", nv, found); end
        @(negedge clk);
        n_cmp++;
        if (timeout_err !== 1'b0 || r0_ready !== 1'b0) begin
            n_err++; $display("FAIL timeout_pulse: got terr=%b r0_ready=%b expected 0/0", timeout_err, r0_ready);
        end
        rv = $urandom;
        r1_valid = 1; r1_addr = $urandom; r1_wstrb = 0;
        @(negedge clk);
        n_cmp++;
        if (mem_valid !== 1'b1 || owner !== 2'd2) begin
            n_err++; $display("FAIL after_timeout_issue: got valid=%b owner=%0d expected 1/2", mem_valid, owner);
        end
        m_last = 1;
        mem_ready = 1; mem_rdata = rv;
        @(negedge clk);
        mem_ready = 0;
        n_cmp++;
        if (r1_ready !== 1'b1 || r1_rdata !== rv || timeout_err !== 1'b0) begin
            n_err++; $display("FAIL after_timeout_resp: got r1_ready=%b rdata=%h terr=%b expected 1/%h/0", r1_ready, r1_rdata, timeout_err, rv);
        end
        r1_valid = 0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        bit got1;
        r0_valid = 1; r0_addr = $urandom; r0_wstrb = 4'hF; r0_wdata = $urandom;
        @(negedge clk);
        n_cmp++;
        if (mem_valid !== 1'b1) begin n_err++; $display("FAIL rst_mid_pre: got valid=%b expected 1", mem_valid); end
        #2 resetn = 0;
        #1;
        n_cmp++;
        if ({mem_valid, owner, r0_ready, r1_ready} !== 5'd0) begin
            n_err++; $display("FAIL rst_mid_async: got valid=%b owner=%0d r0_ready=%b r1_ready=%b expected zeros", mem_valid, owner, r0_ready, r1_ready);
        end
        @(negedge clk);
        r1_valid = 1; r1_addr = $urandom; r1_wstrb = 0;
        resetn = 1;
        m_last = 1;
        @(negedge clk);
        n_cmp++;
        if (mem_valid !== 1'b1 || owner !== 2'd1) begin
            n_err++; $display("FAIL rst_first_tie: got valid=%b owner=%0d expected 1/1", mem_valid, owner);
        end
        m_last = 0;
        mem_ready = 1;
        @(negedge clk);
        mem_ready = 0;
        n_cmp++;
        if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
            n_err++; $display("FAIL rst_first_resp: got r0_ready=%b r1_ready=%b expected 1/0", r0_ready, r1_ready);
        end
        r0_valid = 0;
        got1 = 0;
        for (int c = 0; c < 10 && !got1; c++) begin
            @(negedge clk);
            mem_ready = mem_valid & ~mem_ready;
            if (r1_ready === 1'b1) begin got1 = 1; r1_valid = 0; end
        end
        mem_ready = 0;
        m_last = 1;
        n_cmp++;
        if (!got1) begin n_err++; $display("FAIL rst_second: got no r1_ready expected one pulse"); end
        r1_valid = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_stale_ready;
        mem_ready = 1; mem_rdata = $urandom;
        @(negedge clk);
        mem_ready = 0;
        n_cmp++;
        if ({r0_ready, r1_ready, owner, mem_valid} !== 5'd0) begin
            n_err++; $display("FAIL stale_ready: got r0_ready=%b r1_ready=%b owner=%0d valid=%b expected zeros", r0_ready, r1_ready, owner, mem_valid);
        end
        @(negedge clk);
        r0_valid = 1; r0_addr = $urandom; r0_wstrb = 0;
        @(negedge clk);
        n_cmp++;
        if (mem_valid !== 1'b1 || owner !== 2'd1 || r0_ready !== 1'b0) begin
            n_err++; $display("FAIL stale_then_issue: got valid=%b owner=%0d r0_ready=%b expected 1/1/0", mem_valid, owner, r0_ready);
        end
        m_last = 0;
        mem_ready = 1;
        @(negedge clk);
        mem_ready = 0;
        r0_valid = 0;
        @(negedge clk);
    endtask

    task automatic test_random_traffic;
        logic [31:0] ra[2];
        logic [31:0] rw[2];
        logic [3:0]  rs[2];
        logic        ri[2];
        bit          v[2];
        bit          pv[2];
        bit          rdy;
        bit          prev_mv, pend_resp;
        int          cur, done, cnt, lat, pend_own, want;
        logic [1:0]  exp_own;
        logic [31:0] exp_rd;
        for (int i = 0; i < 2; i++) begin
            ra[i] = '0; rw[i] = '0; rs[i] = '0; ri[i] = 0; v[i] = 0; pv[i] = 0;
        end
        prev_mv = 0; pend_resp = 0; cur = 0; done = 0; cnt = 0; pend_own = 0; exp_rd = '0;
        want = 24;
        lat = $urandom_range(0, 3);
        for (int c = 0; c < 3000 && done < want; c++) begin
            @(negedge clk);
            n_cmp++;
            if (pend_resp) begin
                if ({r0_ready, r1_ready} !== ((pend_own == 1) ? 2'b10 : 2'b01) ||
                    ((pend_own == 1) ? r0_rdata : r1_rdata) !== exp_rd) begin
                    n_err++; $display("FAIL rand_resp: got ready=%b%b rdata0=%h rdata1=%h expected owner %0d data %h",
                                      r0_ready, r1_ready, r0_rdata, r1_rdata, pend_own, exp_rd);
                end
            end else if ({r0_ready, r1_ready} !== 2'b00) begin
                n_err++; $display("FAIL rand_spurious_ready: got ready=%b%b expected 00", r0_ready, r1_ready);
            end
            if (mem_valid && !prev_mv) begin
                exp_own = (pv[0] && pv[1]) ? ((m_last == 0) ? 2'd2 : 2'd1) : pv[0] ? 2'd1 : pv[1] ? 2'd2 : 2'd0;
                n_cmp++;
                if (owner !== exp_own) begin
                    n_err++; $display("FAIL rand_grant: got owner %0d expected %0d (pending %0d%0d)", owner, exp_own, pv[0], pv[1]);
                end
                cur = exp_own;
                if (exp_own != 2'd0) m_last = (exp_own == 2'd2) ? 1 : 0;
            end
            if (mem_valid && cur != 0) begin
                n_cmp++;
                if ({mem_addr, mem_wdata, mem_wstrb, mem_instr} !== {ra[cur-1], rw[cur-1], rs[cur-1], ri[cur-1]}) begin
                    n_err++; $display("FAIL rand_payload: got %h/%h/%h/%b expected %h/%h/%h/%b", mem_addr, mem_wdata, mem_wstrb, mem_instr,
                                      ra[cur-1], rw[cur-1], rs[cur-1], ri[cur-1]);
                end
            end
            for (int i = 0; i < 2; i++) begin
                rdy = (i == 0) ? r0_ready : r1_ready;
                if (rdy && v[i]) begin v[i] = 0; done++; end
                if (!v[i] && $urandom_range(0, 2) != 0) begin
                    v[i] = 1; ra[i] = $urandom; rw[i] = $urandom; rs[i] = 4'($urandom_range(0, 15)); ri[i] = 1'($urandom_range(0, 1));
                end
            end
            r0_valid = v[0]; r0_addr = ra[0]; r0_wdata = rw[0]; r0_wstrb = rs[0]; r0_instr = ri[0];
            r1_valid = v[1]; r1_addr = ra[1]; r1_wdata = rw[1]; r1_wstrb = rs[1]; r1_instr = ri[1];
            mem_ready = 0; pend_resp = 0;
            if (mem_valid) begin
                if (cnt == lat) begin
                    mem_ready = 1; mem_rdata = $urandom; exp_rd = mem_rdata;
                    pend_resp = 1; pend_own = cur; cnt = 0; lat = $urandom_range(0, 3);
                end else cnt++;
            end
            pv[0] = v[0]; pv[1] = v[1]; prev_mv = mem_valid;
        end
        n_cmp++;
        if (done < want) begin n_err++; $display("FAIL rand_progress: got %0d completed transfers expected %0d", done, want); end
        r0_valid = 0; r1_valid = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            mem_ready = mem_valid & ~mem_ready;
        end
        mem_ready = 0;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_read();
        test_write_passthrough();
        test_tie();
        test_timeout();
        test_reset_mid();
        test_stale_ready();
        test_random_traffic();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/picorv32_mem_arbiter.md
Name: picorv32_mem_arbiter

Overview:
- Shares the single PicoRV32 native memory port (valid/ready, addr/wdata/wstrb/rdata) between two requesters.
- Requester 0 is the core's memory interface; requester 1 is the ISAX/SCAL memory port.
- Sits in the generated top between the core instance, the ISAX logic and external memory.
- Performs round-robin arbitration, holds the grant for a whole transfer, and enforces a response timeout.

Parameters:
- TIMEOUT, 256: cycles to wait for mem_ready after issue before aborting; 0 disables the timeout.
- ERR_RDATA, 32'hDEAD_BEEF: read data returned to the owner on a timeout abort.
- FIXED_PRIO, 0: 1 gives requester 0 strict priority; 0 selects round-robin.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- r0_valid  in  1  requester 0 request
- r0_instr  in  1  requester 0 instruction-fetch flag
- r0_addr  in  32  requester 0 address
- r0_wdata  in  32  requester 0 write data
- r0_wstrb  in  4  requester 0 byte strobes; 0 means read
- r0_ready  out  1  requester 0 completion
- r0_rdata  out  32  requester 0 read data
- r1_valid, r1_instr, r1_addr, r1_wdata, r1_wstrb, r1_ready, r1_rdata: same directions, widths and meanings for requester 1
- mem_valid  out  1  downstream request
- mem_instr  out  1  downstream fetch flag
- mem_addr  out  32  downstream address
- mem_wdata  out  32  downstream write data
- mem_wstrb  out  4  downstream strobes
- mem_ready  in  1  downstream completion
- mem_rdata  in  32  downstream read data
- owner  out  2  current owner: 0 none, 1 requester 0, 2 requester 1
- timeout_err  out  1  one-cycle pulse on a timeout abort

Behaviour:
- Interface: one clock (clk); reset (resetn) is asynchronous and active-low.
- Reset values: state=IDLE, last_grant=1 (so requester 0 wins the first tie), mem_valid=0, mem_* data outputs=0, r*_ready=0, owner=0, timeout_err=0, timer=0.
- States: IDLE, ISSUE, ABORT.
- IDLE, arbitration:
  - If any r*_valid is high, select a winner and register mem_addr/mem_wdata/mem_wstrb/mem_instr from it.
  - Set mem_valid=1, set owner, go to ISSUE.
  - Arbitration latency is exactly 1 cycle from request to mem_valid.
- Tie rule: FIXED_PRIO=1 always picks r0. FIXED_PRIO=0 picks the requester not equal to last_grant; last_grant updates to the winner.
- ISSUE:
  - mem_valid is held high with stable registered payload until mem_ready.
  - On a cycle where mem_valid and mem_ready are both high:
    - Register owner's rdata=mem_rdata and owner's ready=1 for exactly one cycle.
    - Clear mem_valid, owner=0, go to IDLE.
  - The non-owner's ready stays 0 throughout.
- Back-to-back: a requester still valid after its ready pulse is re-arbitrated. Minimum cycle per transfer is issue + response + 1 idle cycle, so no requester gets two consecutive grants while the other waits under round-robin.
- Timer: resets to 0 on entering ISSUE and increments each ISSUE cycle without mem_ready. It saturates at its width, which is clog2(TIMEOUT+1).
- Timeout: when TIMEOUT!=0 and timer==TIMEOUT-1 with no mem_ready, go to ABORT.
  - mem_valid drops the next cycle.
  - Owner receives ready=1 with rdata=ERR_RDATA.
  - timeout_err pulses for 1 cycle, owner=0.
  - ABORT lasts one cycle, then IDLE.
- Requester drops valid while owner: protocol violation. Ignored: the transfer completes normally and the ready pulse is still delivered.
- mem_ready in IDLE or ABORT (stale): ignored, no ready to any requester.
- Reset mid-transfer: all outputs return to reset values immediately (async); an in-flight transfer is discarded.
- r*_rdata holds its last value outside ready pulses.

Decomposition:
- Shared package picorv32_arb_pkg:
  - state enum {IDLE, ISSUE, ABORT}
  - owner encoding constants OWN_NONE=0, OWN_R0=1, OWN_R1=2
  - TIMER_W function (clog2)
- One sub-module, picorv32_arb_rr2: a 2-way round-robin/fixed-priority pick. Combinational, with last_grant as input; used by the FSM in IDLE.

Test Plan:
- Single read: r0_valid, addr=0x100, wstrb=0; memory answers mem_ready 2 cycles after mem_valid with rdata=0x12345678 -> mem_valid rises 1 cycle after r0_valid; r0_ready pulses once with r0_rdata=0x12345678; owner 1 -> 0; r1_ready never asserts.
- Tie, round-robin: r0 and r1 valid together continuously, memory ready 1 cycle after issue -> grants alternate r0, r1, r0, r1 over 4 transfers; with FIXED_PRIO=1, all 4 grants go to r0.
- Write passthrough: r1 write addr=0x2000, wdata=0xA5A5A5A5, wstrb=4'b0011 -> mem_addr/mem_wdata/mem_wstrb match exactly and stay stable for every mem_valid cycle; r1_ready pulses once.
- Timeout: TIMEOUT=8, mem_ready held low -> after 8 ISSUE cycles mem_valid drops; r0_ready=1 with r0_rdata=0xDEADBEEF; timeout_err pulses 1 cycle; a later request is served normally.
- Reset mid-transfer: resetn=0 asynchronously during ISSUE -> mem_valid, r*_ready and owner go to 0 without waiting for a clock edge; after release, the first tie is won by r0.
- Stale ready: mem_ready pulsed in IDLE -> no r*_ready asserts and the state is unchanged.
